// File: rtl/jtpang_rom_nslot.sv
// Read-only SDRAM bank client shared by up to four ROM slots.
// Round-robin arbitration, one 32-bit cached line per slot, one request in flight.
module jtpang_rom_nslot #(
  parameter int          SLOTS = 2,
  parameter int          AW    = 20,
  parameter int          DW0   = 8,
  parameter int          DW1   = 8,
  parameter int          DW2   = 8,
  parameter int          DW3   = 8,
  parameter logic [21:0] OFF0  = 22'h0,
  parameter logic [21:0] OFF1  = 22'h0,
  parameter logic [21:0] OFF2  = 22'h0,
  parameter logic [21:0] OFF3  = 22'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*32-1:0]   slot_dout,
  output logic [21:0]           sdram_addr,
  output logic                  sdram_req,
  input  logic                  sdram_ack,
  input  logic                  data_dst,
  input  logic                  data_rdy,
  input  logic [15:0]           data_read,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } state_t;

  function automatic int dw_of(input int n);
    case (n)
      0:       return DW0;
      1:       return DW1;
      2:       return DW2;
      default: return DW3;
    endcase
  endfunction

  function automatic logic [21:0] off_of(input int n);
    case (n)
      0:       return OFF0;
      1:       return OFF1;
      2:       return OFF2;
      default: return OFF3;
    endcase
  endfunction

  function automatic logic [21:0] map_addr(input int dw, input logic [21:0] off,
                                           input logic [AW-1:0] a);
    logic [AW:0] ax;
    ax = {1'b0, a};
    if (dw == 8)       ax = ax >> 1;
    else if (dw == 32) ax = ax << 1;
    return off + 22'(ax);
  endfunction

  function automatic logic [31:0] extract(input int dw, input logic [31:0] line,
                                          input logic lane);
    if (dw == 8)  return lane ? {24'h0, line[15:8]} : {24'h0, line[7:0]};
    if (dw == 16) return {16'h0, line[15:0]};
    return line;
  endfunction

  // Returns {found, index}; search starts at ptr and wraps within SLOTS.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    int         j;
    res = 3'b000;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % SLOTS;
      if (req[2'(j)]) res = {1'b1, 2'(j)};
    end
    return res;
  endfunction

  localparam logic [3:0] IS32 = {dw_of(3) == 32, dw_of(2) == 32, dw_of(1) == 32, dw_of(0) == 32};

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [21:0] addr_q, addr_d;
  logic [1:0]  win_q, win_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] lo_q;

  logic [3:0]  miss_w;
  logic [21:0] map_w [4];
  logic [2:0]  pick_w;
  logic        fill_now_w;
  logic [31:0] fill_line_w;

  assign pick_w      = rr_pick(miss_w, ptr_q);
  assign fill_now_w  = (state_q == WAIT_DATA) && data_rdy;
  assign fill_line_w = IS32[win_q] ? {data_read, lo_q} : {16'h0, data_read};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= 22'h0;
      win_q   <= 2'd0;
      ptr_q   <= 2'd0;
      lo_q    <= 16'h0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      if (state_q == WAIT_DATA && data_dst) lo_q <= data_read;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_w[2]) begin
          win_d   = pick_w[1:0];
          addr_d  = map_w[pick_w[1:0]];
          req_d   = 1'b1;
          ptr_d   = (pick_w[1:0] == 2'(SLOTS - 1)) ? 2'd0 : pick_w[1:0] + 2'd1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (data_rdy) state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign dbg_state  = state_q;

  for (genvar g = 0; g < 4; g++) begin : g_slot
    if (g < SLOTS) begin : g_on
      localparam int DWG = dw_of(g);
      logic [AW-1:0] addr_w;
      logic [21:0]   map_g;
      logic          cached_w, fill_w, fill_hit_w;
      logic [31:0]   line_q, dout_q;
      logic [21:0]   tag_q;
      logic          valid_q, ok_q;

      assign addr_w     = slot_addr[g*AW +: AW];
      assign map_g      = map_addr(DWG, off_of(g), addr_w);
      assign cached_w   = valid_q && (tag_q == map_g);
      assign fill_w     = fill_now_w && (win_q == 2'(g));
      assign fill_hit_w = fill_w && (addr_q == map_g);
      assign map_w[g]   = map_g;
      assign miss_w[g]  = slot_cs[g] && !cached_w;

      // A completing fill is forwarded straight to ok/dout so rdy->ok is one cycle.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          line_q  <= 32'h0;
          tag_q   <= 22'h0;
          valid_q <= 1'b0;
          ok_q    <= 1'b0;
          dout_q  <= 32'h0;
        end else begin
          if (fill_w) begin
            line_q <= fill_line_w;
            tag_q  <= addr_q;
          end
          if (flush)       valid_q <= 1'b0;
          else if (fill_w) valid_q <= 1'b1;
          ok_q <= slot_cs[g] && !flush && (cached_w || fill_hit_w);
          if (slot_cs[g] && !flush) begin
            if (fill_hit_w)    dout_q <= extract(DWG, fill_line_w, addr_w[0]);
            else if (cached_w) dout_q <= extract(DWG, line_q, addr_w[0]);
          end
        end
      end

      assign slot_ok[g]          = ok_q;
      assign slot_dout[g*32 +: 32] = dout_q;
    end else begin : g_off
      assign map_w[g]  = 22'h0;
      assign miss_w[g] = 1'b0;
    end
  end

endmodule

// File: tb/tb_jtpang_rom_nslot.sv
// Bench for jtpang_rom_nslot: two slots (8-bit at offset 0, 32-bit at offset 22'h10000).
// Directed vector table, hand-written corner sequences, then random traffic vs a memory model.
module tb_jtpang_rom_nslot;

  logic        clk, rst_n, flush;
  logic [1:0]  slot_cs;
  logic [39:0] slot_addr;
  logic [1:0]  slot_ok;
  logic [63:0] slot_dout;
  logic [21:0] sdram_addr;
  logic        sdram_req, sdram_ack, data_dst, data_rdy;
  logic [15:0] data_read;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  jtpang_rom_nslot #(
    .SLOTS(2), .AW(20), .DW0(8), .DW1(32), .OFF1(22'h10000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .slot_cs(slot_cs), .slot_addr(slot_addr),
    .slot_ok(slot_ok), .slot_dout(slot_dout), .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: SDRAM contents and slot address map
  function automatic logic [15:0] mem16(input logic [21:0] w);
    return w[15:0] ^ {w[21:16], w[21:12]} ^ 16'h5a3c;
  endfunction

  function automatic logic [21:0] exp_word(input int n, input logic [19:0] a);
    if (n == 0) return 22'(a / 20'd2);
    return 22'h10000 + 22'(a) * 22'd2;
  endfunction

  function automatic logic [31:0] exp_dout(input int n, input logic [19:0] a);
    logic [21:0] w;
    logic [15:0] m;
    w = exp_word(n, a);
    if (n == 0) begin
      m = mem16(w);
      return a[0] ? {24'h0, m[15:8]} : {24'h0, m[7:0]};
    end
    return {mem16(w + 22'd1), mem16(w)};
  endfunction

  // driver tasks
  task automatic serve(input logic [15:0] d0, input logic [15:0] d1, input bit two);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    check("ack_req_drop", sdram_req, 1'b0);
    data_dst  = 1'b1;
    data_rdy  = !two;
    data_read = d0;
    tick();
    if (two) begin
      data_dst  = 1'b0;
      data_rdy  = 1'b1;
      data_read = d1;
      tick();
    end
    data_dst = 1'b0;
    data_rdy = 1'b0;
  endtask

  typedef struct {
    int          slot;
    logic [19:0] addr;
    bit          miss;
    logic [21:0] req_addr;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs [10];

  task automatic run_vec(input vec_t v);
    slot_cs = 2'b00;
    slot_cs[v.slot] = 1'b1;
    slot_addr[v.slot*20 +: 20] = v.addr;
    tick();
    if (v.miss) begin
      check("vec_req", sdram_req, 1'b1);
      check("vec_req_addr", sdram_addr, v.req_addr);
      check("vec_ok_early", slot_ok[v.slot], 1'b0);
      serve(v.d0, v.d1, v.slot == 1);
    end else begin
      check("vec_hit_noreq", sdram_req, 1'b0);
    end
    check("vec_ok", slot_ok[v.slot], 1'b1);
    check("vec_dout", slot_dout[v.slot*32 +: 32], v.dout);
    slot_cs = 2'b00;
    tick();
    check("vec_ok_drop", slot_ok[v.slot], 1'b0);
  endtask

  // random phase state
  int          r_st, r_cnt;
  logic [21:0] r_addr;
  bit          r_two, req_ok;
  int          hold_left [2];
  int          hold_len [2];
  bit          hold_cs [2];
  logic [19:0] hold_addr [2];
  bit          seen_ok [2];
  bit          prev_cs [2];
  logic [19:0] prev_addr [2];

  initial begin
    rst_n = 1'b0; flush = 1'b0; slot_cs = 2'b00; slot_addr = 40'h0;
    sdram_ack = 1'b0; data_dst = 1'b0; data_rdy = 1'b0; data_read = 16'h0;

    vecs[0] = '{0, 20'h00005, 1'b1, 22'h000002, 16'habcd, 16'h0000, 32'h000000ab};
    vecs[1] = '{0, 20'h00004, 1'b0, 22'h000000, 16'h0000, 16'h0000, 32'h000000cd};
    vecs[2] = '{1, 20'h00003, 1'b1, 22'h010006, 16'h1234, 16'h5678, 32'h56781234};
    vecs[3] = '{0, 20'h00005, 1'b0, 22'h000000, 16'h0000, 16'h0000, 32'h000000ab};
    vecs[4] = '{1, 20'h00003, 1'b0, 22'h000000, 16'h0000, 16'h0000, 32'h56781234};
    vecs[5] = '{0, 20'h00007, 1'b1, 22'h000003, 16'h00ff, 16'h0000, 32'h00000000};
    vecs[6] = '{0, 20'h00006, 1'b0, 22'h000000, 16'h0000, 16'h0000, 32'h000000ff};
    vecs[7] = '{1, 20'h00000, 1'b1, 22'h010000, 16'hbeef, 16'hdead, 32'hdeadbeef};
    vecs[8] = '{0, 20'hfffff, 1'b1, 22'h07ffff, 16'h5a3c, 16'h0000, 32'h0000005a};
    vecs[9] = '{1, 20'hfffff, 1'b1, 22'h20fffe, 16'h1111, 16'h2222, 32'h22221111};

    tick();
    tick();
    check("rst_ok", slot_ok, 2'b00);
    check("rst_dout0", slot_dout[31:0], 32'h0);
    check("rst_dout1", slot_dout[63:32], 32'h0);
    check("rst_req", sdram_req, 1'b0);
    check("rst_addr", sdram_addr, 22'h0);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // both slots miss together with the pointer at slot 0
    slot_addr = {20'h00010, 20'h00040};
    slot_cs   = 2'b11;
    tick();
    check("arb_first", sdram_addr, 22'h000020);
    serve(16'h4411, 16'h0, 1'b0);
    check("arb_ok0", slot_ok[0], 1'b1);
    check("arb_dout0", slot_dout[31:0], 32'h11);
    tick();
    check("arb_second_req", sdram_req, 1'b1);
    check("arb_second", sdram_addr, 22'h010020);
    check("arb_ok0_hold", slot_ok[0], 1'b1);
    serve(16'h0a0b, 16'h0c0d, 1'b1);
    check("arb_ok1", slot_ok[1], 1'b1);
    check("arb_dout1", slot_dout[63:32], 32'h0c0d0a0b);
    slot_cs = 2'b00;
    tick();
    // slot 0 wins alone, so slot 1 goes first on the next simultaneous miss
    slot_addr[19:0] = 20'h00044;
    slot_cs = 2'b01;
    tick();
    check("arb_solo", sdram_addr, 22'h000022);
    serve(16'h9900, 16'h0, 1'b0);
    slot_addr = {20'h00012, 20'h00046};
    slot_cs   = 2'b11;
    tick();
    check("arb_rot_first", sdram_addr, 22'h010024);
    serve(16'h0001, 16'h0002, 1'b1);
    check("arb_rot_dout1", slot_dout[63:32], 32'h00020001);
    tick();
    check("arb_rot_second", sdram_addr, 22'h000023);
    serve(16'h3344, 16'h0, 1'b0);
    check("arb_rot_dout0", slot_dout[31:0], 32'h44);
    slot_cs = 2'b00;
    tick();

    // cs dropped after ack: fill completes silently, later request hits
    slot_addr[19:0] = 20'h00050;
    slot_cs = 2'b01;
    tick();
    check("drop_req_addr", sdram_addr, 22'h000028);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    slot_cs = 2'b00;
    data_dst = 1'b1; data_rdy = 1'b1; data_read = 16'h7788;
    tick();
    data_dst = 1'b0; data_rdy = 1'b0;
    check("drop_no_ok", slot_ok[0], 1'b0);
    tick();
    check("drop_no_ok2", slot_ok[0], 1'b0);
    check("drop_no_req", sdram_req, 1'b0);
    slot_cs = 2'b01;
    tick();
    check("drop_hit_ok", slot_ok[0], 1'b1);
    check("drop_hit_dout", slot_dout[31:0], 32'h88);
    check("drop_hit_noreq", sdram_req, 1'b0);
    slot_cs = 2'b00;
    tick();

    // flush together with rdy, then flush on a hit
    slot_addr[19:0] = 20'h00060;
    slot_cs = 2'b01;
    tick();
    check("flush_req_addr", sdram_addr, 22'h000030);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    data_dst = 1'b1; data_rdy = 1'b1; data_read = 16'h2468; flush = 1'b1;
    tick();
    data_dst = 1'b0; data_rdy = 1'b0; flush = 1'b0;
    check("flush_rdy_ok", slot_ok[0], 1'b0);
    tick();
    check("flush_rereq", sdram_req, 1'b1);
    check("flush_rereq_addr", sdram_addr, 22'h000030);
    check("flush_rereq_ok", slot_ok[0], 1'b0);
    serve(16'h1357, 16'h0, 1'b0);
    check("flush_refill_ok", slot_ok[0], 1'b1);
    check("flush_refill_dout", slot_dout[31:0], 32'h57);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_hit_ok", slot_ok[0], 1'b0);
    tick();
    check("flush_hit_req", sdram_req, 1'b1);
    serve(16'h1357, 16'h0, 1'b0);
    check("flush_hit_refill", slot_ok[0], 1'b1);
    slot_cs = 2'b00;
    tick();

    // reset while waiting for data: late strobes must not fill the line
    slot_addr[39:20] = 20'h00020;
    slot_cs = 2'b10;
    tick();
    check("rstw_req_addr", sdram_addr, 22'h010040);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    rst_n = 1'b0;
    slot_cs = 2'b00;
    tick();
    check("rstw_req", sdram_req, 1'b0);
    check("rstw_ok", slot_ok, 2'b00);
    check("rstw_addr", sdram_addr, 22'h0);
    check("rstw_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    data_dst = 1'b1; data_read = 16'haaaa;
    tick();
    data_dst = 1'b0; data_rdy = 1'b1; data_read = 16'hbbbb;
    tick();
    data_rdy = 1'b0;
    check("rstw_late_ok", slot_ok, 2'b00);
    check("rstw_late_req", sdram_req, 1'b0);
    slot_cs = 2'b10;
    tick();
    check("rstw_refetch", sdram_req, 1'b1);
    check("rstw_refetch_addr", sdram_addr, 22'h010040);
    serve(16'h0005, 16'h0006, 1'b1);
    check("rstw_refetch_dout", slot_dout[63:32], 32'h00060005);
    slot_cs = 2'b00;

    // random traffic against the memory model
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    r_st = 0; r_cnt = 0; r_addr = 22'h0; r_two = 1'b0;
    for (int n = 0; n < 2; n++) begin
      hold_left[n] = 0; hold_len[n] = 0; hold_cs[n] = 1'b0; hold_addr[n] = 20'h0;
      seen_ok[n] = 1'b0; prev_cs[n] = 1'b0; prev_addr[n] = 20'h0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      for (int n = 0; n < 2; n++) begin
        if (!prev_cs[n]) check("rnd_ok_nocs", slot_ok[n], 1'b0);
        else if (slot_ok[n]) begin
          check("rnd_dout", slot_dout[n*32 +: 32], exp_dout(n, prev_addr[n]));
          seen_ok[n] = 1'b1;
        end
      end
      sdram_ack = 1'b0; data_dst = 1'b0; data_rdy = 1'b0;
      data_read = 16'($urandom);
      case (r_st)
        0: if (sdram_req) begin
          req_ok = (prev_cs[0] && sdram_addr == exp_word(0, prev_addr[0])) ||
                   (prev_cs[1] && sdram_addr == exp_word(1, prev_addr[1]));
          check("rnd_req_addr", req_ok, 1'b1);
          r_addr = sdram_addr;
          r_two  = r_addr >= 22'h010000;
          r_cnt  = $urandom_range(0, 2);
          r_st   = 1;
        end
        1: begin
          check("rnd_req_hold", sdram_req, 1'b1);
          if (r_cnt == 0) begin
            sdram_ack = 1'b1;
            r_st = 2;
          end else r_cnt--;
        end
        2: begin
          check("rnd_req_drop", sdram_req, 1'b0);
          r_cnt = $urandom_range(0, 3);
          r_st  = 3;
        end
        3: if (r_cnt == 0) begin
          data_dst  = 1'b1;
          data_read = mem16(r_addr);
          if (r_two) r_st = 4;
          else begin
            data_rdy = 1'b1;
            r_st = 0;
          end
        end else r_cnt--;
        4: begin
          data_rdy  = 1'b1;
          data_read = mem16(r_addr + 22'd1);
          r_st = 0;
        end
        default: r_st = 0;
      endcase
      for (int n = 0; n < 2; n++) begin
        if (hold_left[n] == 0) begin
          if (hold_cs[n] && hold_len[n] >= 45) check("rnd_live", seen_ok[n], 1'b1);
          hold_len[n]  = $urandom_range(1, 60);
          hold_left[n] = hold_len[n];
          hold_cs[n]   = $urandom_range(0, 3) != 0;
          hold_addr[n] = (n == 0) ? 20'($urandom_range(0, 15)) : 20'($urandom_range(0, 7));
          seen_ok[n]   = 1'b0;
        end
        hold_left[n]--;
        slot_cs[n] = hold_cs[n];
        slot_addr[n*20 +: 20] = hold_addr[n];
        prev_cs[n]   = hold_cs[n];
        prev_addr[n] = hold_addr[n];
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
